pc_sequencer: RTL and testbench

Multi-cycle fetch/execute controller that owns the program counter for the processor core. It requests instructions from instruction memory over a req/ack handshake, presents the fetched instruction to decode/execute, and waits for execute to finish. It then applies the next-PC rule (taken branch, unconditional branch, or +4). It also counts retired instructions and traps fetch timeouts and misaligned PCs.

---
 rtl/pc_seq_pkg.sv | 25 ++
 rtl/pc_next_calc.sv | 25 ++
 rtl/pc_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM states,
// the sequential PC increment and a helper sizing the fetch wait counter.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    localparam logic [63:0] PC_INC = 64'd4;

    // Smallest width able to hold values 0..max_wait (at least one bit).
    function automatic int wait_width(input int max_wait);
        int w;
        w = 1;
        while ((1 << w) <= max_wait) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC rule: branch target when the branch is taken,
// sequential PC otherwise, plus an alignment flag for the result.
module pc_next_calc
    import pc_seq_pkg::*;
(
    input  logic [63:0] pc,
    input  logic [63:0] imm,
    input  logic        branch,
    input  logic        uncond_branch,
    input  logic        alu_zero,
    output logic [63:0] next_pc,
    output logic        misaligned
);

    // Unconditional wins, but both branch forms share the same target anyway.
    always_comb begin
        if (uncond_branch || (branch && alu_zero)) begin
            next_pc = pc + imm;
        end else begin
            next_pc = pc + PC_INC;
        end
        misaligned = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller owning the program counter. Fetches over a
// req/ack handshake, holds the instruction through execute, advances the
// PC, counts retirements and traps fetch timeouts and misaligned PCs.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        Start,
    input  logic [63:0] StartPC,
    output logic        ImemReq,
    output logic [63:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    input  logic        ExecDone,
    input  logic        Branch,
    input  logic        Uncondbranch,
    input  logic        ALUZero,
    input  logic [63:0] SignExtImm64,
    input  logic        Halt,
    output logic [63:0] CurrentPC,
    output logic [63:0] RetireCount,
    output logic        Halted,
    output logic        Fault
);

    localparam int WAIT_W = wait_width(MAX_WAIT);
    // Last fetch cycle allowed without an ack; no ack here means a fault.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state_reg, state_next;
    logic [63:0]       pc_reg, pc_next;
    logic [31:0]       instr_reg, instr_next;
    logic              instr_valid_reg, instr_valid_next;
    logic              imem_req_reg, imem_req_next;
    logic [63:0]       retire_reg, retire_next;
    logic              halted_reg, halted_next;
    logic              fault_reg, fault_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;

    logic [63:0]       calc_next_pc;
    logic              calc_misaligned;
    logic              start_ok;
    logic              start_misaligned;

    pc_next_calc u_next (
        .pc            (pc_reg),
        .imm           (SignExtImm64),
        .branch        (Branch),
        .uncond_branch (Uncondbranch),
        .alu_zero      (ALUZero),
        .next_pc       (calc_next_pc),
        .misaligned    (calc_misaligned)
    );

    // Start is only honoured while not running an instruction.
    assign start_ok = Start && ((state_reg == ST_IDLE) ||
                                (state_reg == ST_HALTED) ||
                                (state_reg == ST_FAULT));
    assign start_misaligned = (StartPC[1:0] != 2'b00);

    // State and every output register; reset drops the fetch request at once.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= '0;
            instr_reg       <= '0;
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b0;
            retire_reg      <= '0;
            halted_reg      <= 1'b0;
            fault_reg       <= 1'b0;
            wait_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instr_reg       <= instr_next;
            instr_valid_reg <= instr_valid_next;
            imem_req_reg    <= imem_req_next;
            retire_reg      <= retire_next;
            halted_reg      <= halted_next;
            fault_reg       <= fault_next;
            wait_reg        <= wait_next;
        end
    end

    // Next-state decision.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_HALTED, ST_FAULT: begin
                if (start_ok) begin
                    state_next = start_misaligned ? ST_FAULT : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (ImemAck) begin
                    state_next = ST_EXEC;
                end else if (wait_reg == WAIT_LAST) begin
                    state_next = ST_FAULT;
                end
            end
            ST_EXEC: begin
                if (ExecDone) begin
                    if (Halt) begin
                        state_next = ST_HALTED;
                    end else if (calc_misaligned) begin
                        state_next = ST_FAULT;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds by default.
    always_comb begin
        pc_next          = pc_reg;
        instr_next       = instr_reg;
        instr_valid_next = instr_valid_reg;
        imem_req_next    = imem_req_reg;
        retire_next      = retire_reg;
        halted_next      = halted_reg;
        fault_next       = fault_reg;
        wait_next        = wait_reg;
        if (start_ok) begin
            pc_next          = StartPC;
            retire_next      = '0;
            wait_next        = '0;
            halted_next      = 1'b0;
            fault_next       = start_misaligned;
            instr_valid_next = 1'b0;
            imem_req_next    = !start_misaligned;
        end else if (state_reg == ST_FETCH) begin
            if (ImemAck) begin
                instr_next       = ImemData;
                instr_valid_next = 1'b1;
                imem_req_next    = 1'b0;
            end else if (wait_reg == WAIT_LAST) begin
                imem_req_next = 1'b0;
                fault_next    = 1'b1;
            end else begin
                wait_next = wait_reg + 1'b1;
            end
        end else if (state_reg == ST_EXEC && ExecDone) begin
            instr_valid_next = 1'b0;
            retire_next      = retire_reg + 64'd1;
            if (Halt) begin
                halted_next = 1'b1;
            end else begin
                pc_next = calc_next_pc;
                if (calc_misaligned) begin
                    fault_next = 1'b1;
                end else begin
                    imem_req_next = 1'b1;
                    wait_next     = '0;
                end
            end
        end
    end

    assign ImemReq     = imem_req_reg;
    assign ImemAddr    = pc_reg;
    assign CurrentPC   = pc_reg;
    assign Instruction = instr_reg;
    assign InstrValid  = instr_valid_reg;
    assign RetireCount = retire_reg;
    assign Halted      = halted_reg;
    assign Fault       = fault_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, branch rules, PC wrap,
// fetch timeout, halt, misalignment traps and asynchronous reset.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic        Start = 1'b0;
    logic [63:0] StartPC = '0;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemAck = 1'b0;
    logic [31:0] ImemData = '0;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        ExecDone = 1'b0;
    logic        Branch = 1'b0;
    logic        Uncondbranch = 1'b0;
    logic        ALUZero = 1'b0;
    logic [63:0] SignExtImm64 = '0;
    logic        Halt = 1'b0;
    logic [63:0] CurrentPC;
    logic [63:0] RetireCount;
    logic        Halted;
    logic        Fault;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.MAX_WAIT(15)) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .Start        (Start),
        .StartPC      (StartPC),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemAck      (ImemAck),
        .ImemData     (ImemData),
        .Instruction  (Instruction),
        .InstrValid   (InstrValid),
        .ExecDone     (ExecDone),
        .Branch       (Branch),
        .Uncondbranch (Uncondbranch),
        .ALUZero      (ALUZero),
        .SignExtImm64 (SignExtImm64),
        .Halt         (Halt),
        .CurrentPC    (CurrentPC),
        .RetireCount  (RetireCount),
        .Halted       (Halted),
        .Fault        (Fault)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [63:0] pc);
        Start = 1'b1;
        StartPC = pc;
        tick();
        Start = 1'b0;
        $display("start   pc=%h req=%0b fault=%0b", pc, ImemReq, Fault);
    endtask

    task automatic do_fetch(input logic [31:0] data);
        ImemAck = 1'b1;
        ImemData = data;
        tick();
        ImemAck = 1'b0;
        $display("fetch   addr=%h instr=%h valid=%0b", ImemAddr, Instruction, InstrValid);
    endtask

    task automatic do_exec(input logic br, input logic ub, input logic z,
                           input logic [63:0] imm, input logic h);
        Branch = br;
        Uncondbranch = ub;
        ALUZero = z;
        SignExtImm64 = imm;
        Halt = h;
        ExecDone = 1'b1;
        tick();
        ExecDone = 1'b0;
        Branch = 1'b0;
        Uncondbranch = 1'b0;
        ALUZero = 1'b0;
        SignExtImm64 = '0;
        Halt = 1'b0;
        $display("exec    pc=%h retired=%0d halted=%0b fault=%0b", CurrentPC, RetireCount, Halted, Fault);
    endtask

    task automatic restart(input logic [63:0] pc);
        Reset_L = 1'b0;
        tick();
        Reset_L = 1'b1;
        do_start(pc);
    endtask

    task automatic test_reset();
        tick();
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b expected 0", ImemReq); end
        checks++; if (ImemAddr !== 64'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", ImemAddr); end
        checks++; if (InstrValid !== 1'b0 || Instruction !== 32'h0) begin errors++; $display("FAIL rst_instr: got %0b/%h expected 0/0", InstrValid, Instruction); end
        checks++; if (RetireCount !== 64'h0 || CurrentPC !== 64'h0) begin errors++; $display("FAIL rst_count: got %h/%h expected 0/0", RetireCount, CurrentPC); end
        checks++; if (Halted !== 1'b0 || Fault !== 1'b0) begin errors++; $display("FAIL rst_flags: got %0b/%0b expected 0/0", Halted, Fault); end
        Reset_L = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        logic [63:0] exp_pc;
        do_start(64'h1000);
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 64'h1000) begin errors++; $display("FAIL seq_start: got req=%0b addr=%h expected 1/1000", ImemReq, ImemAddr); end
        for (int i = 0; i < 3; i++) begin
            exp_pc = 64'h1000 + 64'(4 * i);
            checks++; if (ImemAddr !== exp_pc) begin errors++; $display("FAIL seq_addr%0d: got %h expected %h", i, ImemAddr, exp_pc); end
            do_fetch(32'hA000_0000 + 32'(i));
            checks++; if (InstrValid !== 1'b1 || ImemReq !== 1'b0 || Instruction !== 32'hA000_0000 + 32'(i)) begin
                errors++; $display("FAIL seq_fetch%0d: got valid=%0b req=%0b instr=%h", i, InstrValid, ImemReq, Instruction); end
            if (i == 1) begin
                Start = 1'b1;
                StartPC = 64'h9000;
                tick();
                Start = 1'b0;
                checks++; if (CurrentPC !== exp_pc || InstrValid !== 1'b1) begin errors++; $display("FAIL seq_start_in_exec: got pc=%h valid=%0b expected %h/1", CurrentPC, InstrValid, exp_pc); end
            end
            do_exec(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
            checks++; if (InstrValid !== 1'b0 || ImemReq !== 1'b1 || ImemAddr !== exp_pc + 64'd4) begin
                errors++; $display("FAIL seq_next%0d: got valid=%0b req=%0b addr=%h expected 0/1/%h", i, InstrValid, ImemReq, ImemAddr, exp_pc + 64'd4); end
        end
        checks++; if (RetireCount !== 64'd3) begin errors++; $display("FAIL seq_retire: got %0d expected 3", RetireCount); end
        ExecDone = 1'b1;
        tick();
        ExecDone = 1'b0;
        checks++; if (RetireCount !== 64'd3 || ImemReq !== 1'b1) begin errors++; $display("FAIL seq_execdone_in_fetch: got retire=%0d req=%0b expected 3/1", RetireCount, ImemReq); end
    endtask

    task automatic test_branch();
        logic        br [5];
        logic        ub [5];
        logic        z  [5];
        logic [63:0] imm [5];
        logic [63:0] exp [5];
        br[0] = 1; ub[0] = 0; z[0] = 1; imm[0] = 64'hFFFF_FFFF_FFFF_FFF0; exp[0] = 64'h1FF0;
        br[1] = 1; ub[1] = 0; z[1] = 0; imm[1] = 64'hFFFF_FFFF_FFFF_FFF0; exp[1] = 64'h2004;
        br[2] = 0; ub[2] = 1; z[2] = 0; imm[2] = 64'h40;                  exp[2] = 64'h2040;
        br[3] = 1; ub[3] = 1; z[3] = 0; imm[3] = 64'h40;                  exp[3] = 64'h2040;
        br[4] = 0; ub[4] = 0; z[4] = 1; imm[4] = 64'h40;                  exp[4] = 64'h2004;
        for (int i = 0; i < 5; i++) begin
            restart(64'h2000);
            do_fetch(32'hB000_0000 + 32'(i));
            do_exec(br[i], ub[i], z[i], imm[i], 1'b0);
            checks++; if (ImemAddr !== exp[i] || CurrentPC !== exp[i] || ImemReq !== 1'b1 || Fault !== 1'b0) begin
                errors++; $display("FAIL branch%0d: got addr=%h pc=%h req=%0b fault=%0b expected %h", i, ImemAddr, CurrentPC, ImemReq, Fault, exp[i]); end
        end
    endtask

    task automatic test_wrap();
        restart(64'hFFFF_FFFF_FFFF_FFFC);
        do_fetch(32'h1234_5678);
        do_exec(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (ImemAddr !== 64'h0 || Fault !== 1'b0 || ImemReq !== 1'b1 || RetireCount !== 64'd1) begin
            errors++; $display("FAIL wrap: got addr=%h fault=%0b req=%0b retire=%0d expected 0/0/1/1", ImemAddr, Fault, ImemReq, RetireCount); end
    endtask

    task automatic test_timeout();
        restart(64'h4000);
        for (int k = 1; k <= 15; k++) begin
            checks++; if (Fault !== 1'b0 || ImemReq !== 1'b1) begin errors++; $display("FAIL timeout_early%0d: got fault=%0b req=%0b expected 0/1", k, Fault, ImemReq); end
            tick();
        end
        checks++; if (Fault !== 1'b1 || ImemReq !== 1'b0) begin errors++; $display("FAIL timeout_fault: got fault=%0b req=%0b expected 1/0", Fault, ImemReq); end
        ImemAck = 1'b1;
        ImemData = 32'hDEAD_BEEF;
        tick();
        ImemAck = 1'b0;
        checks++; if (InstrValid !== 1'b0 || Fault !== 1'b1) begin errors++; $display("FAIL timeout_ack_ignored: got valid=%0b fault=%0b expected 0/1", InstrValid, Fault); end
        do_start(64'h5000);
        checks++; if (Fault !== 1'b0 || ImemReq !== 1'b1 || ImemAddr !== 64'h5000) begin
            errors++; $display("FAIL timeout_restart: got fault=%0b req=%0b addr=%h expected 0/1/5000", Fault, ImemReq, ImemAddr); end
    endtask

    task automatic test_halt();
        restart(64'h3000);
        do_fetch(32'h0000_0001);
        do_exec(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        do_fetch(32'h0000_0002);
        do_exec(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        do_fetch(32'h0000_0003);
        do_exec(1'b1, 1'b0, 1'b1, 64'h100, 1'b1);
        checks++; if (Halted !== 1'b1 || CurrentPC !== 64'h3008 || ImemReq !== 1'b0 || RetireCount !== 64'd3 || InstrValid !== 1'b0) begin
            errors++; $display("FAIL halt: got halted=%0b pc=%h req=%0b retire=%0d valid=%0b expected 1/3008/0/3/0", Halted, CurrentPC, ImemReq, RetireCount, InstrValid); end
        ImemAck = 1'b1;
        ExecDone = 1'b1;
        tick();
        ImemAck = 1'b0;
        ExecDone = 1'b0;
        checks++; if (Halted !== 1'b1 || ImemReq !== 1'b0 || RetireCount !== 64'd3 || CurrentPC !== 64'h3008) begin
            errors++; $display("FAIL halt_hold: got halted=%0b req=%0b retire=%0d pc=%h", Halted, ImemReq, RetireCount, CurrentPC); end
        do_start(64'h3000);
        checks++; if (Halted !== 1'b0 || RetireCount !== 64'd0 || ImemReq !== 1'b1) begin
            errors++; $display("FAIL halt_restart: got halted=%0b retire=%0d req=%0b expected 0/0/1", Halted, RetireCount, ImemReq); end
        do_fetch(32'h0000_0004);
        do_exec(1'b1, 1'b0, 1'b1, 64'h6, 1'b0);
        checks++; if (Fault !== 1'b1 || CurrentPC !== 64'h3006 || ImemReq !== 1'b0 || RetireCount !== 64'd1) begin
            errors++; $display("FAIL misalign_branch: got fault=%0b pc=%h req=%0b retire=%0d expected 1/3006/0/1", Fault, CurrentPC, ImemReq, RetireCount); end
    endtask

    task automatic test_misaligned_start();
        do_start(64'h7002);
        checks++; if (Fault !== 1'b1 || ImemReq !== 1'b0 || CurrentPC !== 64'h7002) begin
            errors++; $display("FAIL misalign_start: got fault=%0b req=%0b pc=%h expected 1/0/7002", Fault, ImemReq, CurrentPC); end
        do_start(64'h7000);
        checks++; if (Fault !== 1'b0 || ImemReq !== 1'b1 || ImemAddr !== 64'h7000) begin
            errors++; $display("FAIL aligned_restart: got fault=%0b req=%0b addr=%h expected 0/1/7000", Fault, ImemReq, ImemAddr); end
    endtask

    task automatic test_reset_mid();
        checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got req=%0b expected 1", ImemReq); end
        #2;
        Reset_L = 1'b0;
        #1;
        checks++; if (ImemReq !== 1'b0 || ImemAddr !== 64'h0 || CurrentPC !== 64'h0 || RetireCount !== 64'h0) begin
            errors++; $display("FAIL rstmid_async: got req=%0b addr=%h pc=%h retire=%0d expected all 0", ImemReq, ImemAddr, CurrentPC, RetireCount); end
        checks++; if (InstrValid !== 1'b0 || Instruction !== 32'h0 || Halted !== 1'b0 || Fault !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags: got valid=%0b instr=%h halted=%0b fault=%0b expected all 0", InstrValid, Instruction, Halted, Fault); end
        ImemAck = 1'b1;
        ImemData = 32'hCAFE_F00D;
        tick();
        Reset_L = 1'b1;
        tick();
        ImemAck = 1'b0;
        checks++; if (InstrValid !== 1'b0 || ImemReq !== 1'b0 || Instruction !== 32'h0) begin
            errors++; $display("FAIL rstmid_ack_ignored: got valid=%0b req=%0b instr=%h expected 0/0/0", InstrValid, ImemReq, Instruction); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wrap();
        test_timeout();
        test_halt();
        test_misaligned_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
